// File: rtl/enc_pkg.sv
// Shared defaults and FSM state type for the event encoder.
package enc_pkg;
    localparam int N_DEF = 8;
    localparam int W_DEF = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: lowest set bit at or above ptr,
// falling back to the lowest set bit overall when nothing lies above ptr.
module rr_pick
    import enc_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic [N-1:0] pending,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);
    logic [N-1:0] upper;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_upper
            assign upper[gi] = pending[gi] & (ptr <= W'(gi));
        end
    endgenerate

    // The second scan overrides the wrapped result whenever a bit at or above ptr exists.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i]) idx = W'(i);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (upper[i]) idx = W'(i);
        end
        any = |pending;
    end
endmodule

// File: rtl/event_encoder.sv
// Collects request lines into a pending register and hands out one line index
// at a time over valid/ready, serving lines in round-robin order.
module event_encoder
    import enc_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [W-1:0] code,
    output logic         valid,
    input  logic         ready,
    output logic [N-1:0] pending,
    output logic         overflow
);
    state_t       state;
    logic [W-1:0] ptr;
    logic [W-1:0] pick_idx;
    logic         pick_any;
    logic [N-1:0] clr;

    rr_pick #(.N(N), .W(W)) u_rr_pick (
        .pending (pending),
        .ptr     (ptr),
        .idx     (pick_idx),
        .any     (pick_any)
    );

    assign clr = (valid && ready) ? (N'(1) << code) : '0;

    // OR-ing req after the clear lets a same-cycle request keep its bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending  <= (pending & ~clr) | req;
            overflow <= |(req & pending & ~clr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            code  <= '0;
            valid <= 1'b0;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        code  <= pick_idx;
                        valid <= 1'b1;
                        state <= HOLD;
                    end else begin
                        valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (ready) begin
                        ptr   <= code + W'(1);
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/event_encoder.md
# event_encoder

Event encoder that collects single-cycle or level requests on 8 lines into a pending register. It issues the index of one pending line at a time as a 3-bit code over a valid/ready handshake. Selection is round-robin so every line is served fairly. It is the inverse of the team's 3-to-8 one-hot decoder and sits between peripheral event sources and the controller that dispatches on a binary event number.

## Interface
Parameters:
- N, 8, number of request lines (must be a power of two)
- W, 3, code width, equal to log2(N)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low
- req  input  N  request lines; a 1 in any sampled cycle marks that line pending
- code  output  W  index of the granted line; valid only while valid=1
- valid  output  1  a grant is presented on code
- ready  input  1  consumer accepts the grant when valid and ready are both 1 at a clock edge
- pending  output  N  current pending register, for status readback
- overflow  output  1  one-cycle pulse: a request arrived on a line that was already pending and was not being cleared

## Operation
- Pending update every edge: pending <= (pending & ~clr) | req.
  - clr is the one-hot of code when valid && ready, otherwise 0.
  - Set wins over clear: if req[code] is high in the accepting cycle, that bit stays 1.
- overflow is registered: overflow <= |(req & pending & ~clr).
- State machine, states IDLE and HOLD:
  - IDLE: if pending != 0, register code = rr_pick(pending, ptr), set valid=1, go to HOLD. If pending == 0, stay in IDLE with valid=0.
  - HOLD: code and valid hold steady while ready=0. New requests, including those on lines that would win the round-robin search, do not change code. On valid && ready: clear the pending bit, set ptr <= code+1 (mod N, so 7 wraps to 0), set valid=0, go to IDLE.
- Round-robin: rr_pick returns the first set bit at index ≥ ptr. If none is found it wraps and searches from index 0 upward.
- Arithmetic: ptr and code are W bits; wrap-around comes from natural modulo-2^W overflow.
- Reset values: pending=0, code=0, valid=0, overflow=0, ptr=0, state=IDLE.
- Reset asserted mid-operation (either state): all state clears immediately and asynchronously. Pending requests and any in-flight grant are lost; no acceptance is reported.

## Timing
- Request to grant latency, from an empty state: req high in cycle 0 sets pending after edge 1, and valid=1 appears after edge 2.
- Acceptance happens at the edge where valid && ready. valid is 0 for the following cycle, and the next grant appears at the edge after that.
- Peak throughput is one grant every 2 cycles.
- ready may be held high continuously; it is sampled only while valid=1.
- code must not change while valid=1 and the grant has not been accepted.
- pending reflects the register directly, with no extra latency.
- overflow is asserted for exactly one cycle, on the edge after the offending req.

## Structure
- Shared package enc_pkg holds:
  - the N and W defaults
  - the state typedef with values IDLE and HOLD
- Sub-module rr_pick: a purely combinational round-robin priority encoder. Inputs are pending[N-1:0] and ptr[W-1:0]; outputs are idx[W-1:0] and any. It is the natural reusable piece.
- The top level holds the pending register, ptr, the FSM and the output registers.

## Test plan
- Reset: drive rst_n=0 with req=8'hFF → code=0, valid=0, pending=0, overflow=0. Release reset; valid rises 2 edges after the first sampled req.
- Single request: req=8'b0010_0000 for one cycle with ready=1 → valid=1 and code=5 after 2 edges. pending[5] clears on acceptance, then valid=0.
- All lines at once: req=8'hFF for one cycle, ready=1, ptr=0 → codes 0,1,…,7 in order, one grant per 2 cycles, pending ends at 0.
- Wrap-around: after granting 5 (ptr=6), pending=8'b0100_0001 → grants 6 then 0. With pending=8'b0000_0001 and ptr=6 → grant 0.
- Backpressure: hold ready=0 for 5 cycles with code=3 presented, and raise req[0] meanwhile → code=3 and valid=1 stay steady. After ready=1, the next grant is 0 (round-robin from ptr=4 wraps to 0).
- Overflow, set-wins and reset:
  - req[3] while pending[3]=1 and not accepting → overflow=1 for one cycle.
  - req[3] in the same cycle that code=3 is accepted → pending[3] stays 1 and overflow stays 0.
  - rst_n pulsed low during HOLD → all outputs return to their reset values.
